// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between instruction fetch and
// the memory stage. Accesses are serialized through IDLE -> ISSUE -> WAIT -> DONE.
// Data requests win over fetch requests, because the data access belongs to
// the older instruction.
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive data
// grants made while fetch is waiting, the next grant is forced to fetch.
module mem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_req,
  input  logic [WIDTH-1:0] f_addr,
  output logic [WIDTH-1:0] f_rdata,
  output logic             f_ready,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [2:0]       d_mode,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       mem_mode,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             stall_f,
  output logic             stall_m,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state, state_nxt;
  logic   owner_d;   // 1: current access belongs to the memory stage
  logic   grant_d;   // arbitration result, only meaningful in IDLE
  logic   arb;       // an access is being started this cycle

  assign arb = (state == IDLE) && (f_req || d_req);

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;

  assign grant_d = d_req && !(f_req && (starve_cnt == CW'(STARVE_MAX)));

  // count data grants taken while fetch was also waiting
  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (arb) begin
      if (grant_d && f_req) starve_cnt <= starve_cnt + 1'b1;
      else                  starve_cnt <= '0;
    end
  end
`else
  assign grant_d = d_req;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    f_ready   = 1'b0;
    d_ready   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (f_req || d_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_req = 1'b1;
        if (mem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) state_nxt = DONE;
      end
      DONE: begin
        f_ready   = !owner_d;
        d_ready   = owner_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // latch the winner's request; fields stay stable until the next grant.
  // Fetches have no store data, so wdata is zeroed for them.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_d   <= 1'b0;
      mem_we    <= 1'b0;
      mem_mode  <= 3'b000;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (arb) begin
      owner_d   <= grant_d;
      mem_we    <= grant_d && d_we;
      mem_mode  <= grant_d ? d_mode : 3'b010;
      mem_addr  <= grant_d ? d_addr : f_addr;
      mem_wdata <= grant_d ? d_wdata : '0;
    end
  end

  // capture returned read data for loads and fetches; stores leave it alone
  always_ff @(posedge clk) begin
    if (rst) begin
      f_rdata <= '0;
      d_rdata <= '0;
    end else if (state == WAIT && mem_rvalid && !mem_we) begin
      if (owner_d) d_rdata <= mem_rdata;
      else         f_rdata <= mem_rdata;
    end
  end

  assign stall_f = f_req && !f_ready;
  assign stall_m = d_req && !d_ready;

endmodule
